vec_exec_sequencer: RTL and testbench
=====================================

Name: vec_exec_sequencer

Overview:
- Lane-serial controller for the vector side of the execute stage.
- Accepts one vector instruction at a time: two 192-bit operands, or one vector plus a broadcast scalar.
- Sequences a single shared lane ALU over all lanes, one lane per cycle, and optionally accumulates a reduction sum.
- Returns the 192-bit result and the 21-bit sum through a valid/ready handshake toward writeback.

Parameters:
LANES, 8, number of lanes per vector register
LANE_W, 24, lane width in bits (LANES*LANE_W = 192)
SUM_W, 21, reduction sum width (matches scalar datapath width)
SCAL_W, 21, scalar operand width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
in_valid  input  1  instruction offered
in_ready  output  1  block can accept (high only in IDLE)
op  input  3  lane operation, vec_exec_pkg::lane_op_t
mode_bcast  input  1  1: operand B = scal zero-extended to every lane
red_en  input  1  1: produce reduction sum of lane results
vec_a  input  192  operand A, lane i = bits [i*24+23 : i*24]
vec_b  input  192  operand B (ignored when mode_bcast=1)
scal  input  21  broadcast scalar
flush  input  1  synchronous abort, returns to IDLE
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_vec  output  192  lane results
res_sum  output  21  reduction sum (0 when red_en was 0)
busy  output  1  state != IDLE
lane_idx  output  3  lane being processed (0 outside RUN)

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; res_valid=0; res_vec=0; res_sum=0; lane_idx=0.
  - All captured operand and op registers are cleared.
  - Reset overrides every other input, including reset during RUN or DONE.
- States IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready & !flush:
    - Capture op, mode_bcast, red_en, vec_a, and operand B (vec_b, or scal zero-extended to LANE_W, replicated across lanes).
    - Clear the accumulator and lane_idx; go to RUN.
- RUN: one lane per cycle.
  - Lane lane_idx result is written into res_vec lane slot at the edge.
  - If red_en, the accumulator adds the zero-extended lane result modulo 2^SUM_W.
  - lane_idx increments each cycle. When lane_idx=LANES-1, go to DONE.
  - RUN lasts exactly LANES cycles; res_valid rises LANES cycles after the accepting edge.
- DONE: res_valid=1; res_vec and res_sum held stable; in_ready=0.
  - On res_ready, go to IDLE and res_valid falls.
  - A new instruction is accepted no earlier than the following IDLE cycle; there is no same-cycle turnaround.
- flush (any state except under reset):
  - Next state IDLE; res_valid=0; accumulator and res_sum cleared.
  - flush with in_valid in IDLE: flush wins, no accept.
  - flush in DONE discards the result.
- Lane ops, unsigned, result width LANE_W, wrap mod 2^24:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 MAX, 6 MIN, 7 PASSA.
- res_sum = accumulator, visible in DONE; 0 when red_en=0.
- Partial res_vec contents during RUN are not architecturally visible; consumers sample only when res_valid=1.
- Inputs other than res_ready and flush are ignored outside IDLE.

Decomposition:
- Package vec_exec_pkg:
  - lane_op_t enum (3 bits, encodings above).
  - state_t enum {IDLE, RUN, DONE}.
  - LANES, LANE_W, SUM_W, SCAL_W constants.
  - Lane slice helper function.
- Sub-module vec_lane_alu: purely combinational.
  - Inputs: a, b [LANE_W], op. Output: y [LANE_W].
  - Instantiated once and shared across lanes by the sequencer.

Test Plan:
- ADD, red_en=1, vec_a lane i = i+1, vec_b lanes = 0x10:
  - res_vec lanes 0x11..0x18; res_sum = 0x0000A4.
  - res_valid rises exactly 8 cycles after the accepting edge.
- SUB, red_en=1, vec_a=0, vec_b lanes=1:
  - Every lane 0xFFFFFF; res_sum = 0x1FFFF8 (8*0xFFFFFF mod 2^21).
- mode_bcast=1, op=AND, vec_a all 0xFFFFFF, scal=0x1FFFFF, vec_b=random:
  - Every lane 0x1FFFFF; vec_b has no effect; res_sum=0 with red_en=0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE:
  - res_valid, res_vec, res_sum stable; in_ready=0; in_valid ignored.
  - res_ready=1 → IDLE next cycle, in_ready=1.
- flush asserted when lane_idx=3:
  - Next cycle IDLE, busy=0, res_sum=0, res_valid never asserts.
  - flush together with in_valid in IDLE → no accept.
- rst=0 during RUN at lane 5, then released:
  - All outputs at reset values.
  - A new MAX instruction (a lanes 0x000005, b lanes 0x000007) completes with all lanes 0x000007.

Source files
------------

// File: rtl/vec_exec_pkg.sv
// Shared types and constants for the lane-serial vector execute sequencer.
// lane_slice() extracts one LANE_W-bit lane from a packed vector register.
package vec_exec_pkg;
  localparam int LANES  = 8;
  localparam int LANE_W = 24;
  localparam int SUM_W  = 21;
  localparam int SCAL_W = 21;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int IDX_W  = $clog2(LANES);

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_MAX   = 3'd5,
    OP_MIN   = 3'd6,
    OP_PASSA = 3'd7
  } lane_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [LANE_W-1:0] lane_slice(input logic [VEC_W-1:0] v,
                                                   input logic [IDX_W-1:0] idx);
    return v[idx*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/vec_lane_alu.sv
// Combinational unsigned lane ALU; one instance is time-shared across all lanes.
module vec_lane_alu
  import vec_exec_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  lane_op_t          op,
  output logic [LANE_W-1:0] y
);
  always_comb begin
    y = a;
    unique case (op)
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_MAX:   y = (a > b) ? a : b;
      OP_MIN:   y = (a < b) ? a : b;
      OP_PASSA: y = a;
      default:  y = a;
    endcase
  end
endmodule

// File: rtl/vec_exec_sequencer.sv
// Lane-serial vector execute controller: captures one instruction, walks the shared
// lane ALU over every lane, optionally reduces, and hands the result to writeback.
module vec_exec_sequencer
  import vec_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic              mode_bcast,
  input  logic              red_en,
  input  logic [VEC_W-1:0]  vec_a,
  input  logic [VEC_W-1:0]  vec_b,
  input  logic [SCAL_W-1:0] scal,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [VEC_W-1:0]  res_vec,
  output logic [SUM_W-1:0]  res_sum,
  output logic              busy,
  output logic [IDX_W-1:0]  lane_idx
);
  state_t             state_q;
  lane_op_t           op_q;
  logic               red_q;
  logic [VEC_W-1:0]   a_q;
  logic [VEC_W-1:0]   b_q;
  logic [VEC_W-1:0]   res_vec_q;
  logic [SUM_W-1:0]   acc_q;
  logic [SUM_W-1:0]   acc_d;
  logic [IDX_W-1:0]   lane_q;
  logic               res_valid_q;
  logic [VEC_W-1:0]   b_sel;
  logic [LANE_W-1:0]  lane_y;

  // Broadcast mode replaces every lane of B with the zero-extended scalar.
  assign b_sel = mode_bcast ? {LANES{{(LANE_W-SCAL_W){1'b0}}, scal}} : vec_b;

  vec_lane_alu u_alu (
    .a  (lane_slice(a_q, lane_q)),
    .b  (lane_slice(b_q, lane_q)),
    .op (op_q),
    .y  (lane_y)
  );

  // Only the low SUM_W bits of a lane affect a sum taken modulo 2^SUM_W.
  assign acc_d = acc_q + lane_y[SUM_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      red_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_vec_q   <= '0;
      acc_q       <= '0;
      lane_q      <= '0;
      res_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      lane_q      <= '0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= lane_op_t'(op);
            red_q   <= red_en;
            a_q     <= vec_a;
            b_q     <= b_sel;
            acc_q   <= '0;
            lane_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_vec_q[lane_q*LANE_W +: LANE_W] <= lane_y;
          if (red_q) acc_q <= acc_d;
          if (lane_q == IDX_W'(LANES-1)) begin
            lane_q      <= '0;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_vec   = res_vec_q;
  assign res_sum   = acc_q;
  assign lane_idx  = lane_q;
endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops them on each
// result handshake; directed phases cover latency, backpressure, flush and reset.
module tb_vec_exec_sequencer;
  localparam int L = 8;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, mode_bcast, red_en, flush;
  logic         res_valid, res_ready, busy;
  logic [2:0]   op, lane_idx;
  logic [191:0] vec_a, vec_b, res_vec;
  logic [20:0]  scal, res_sum;

  typedef struct packed {
    logic [191:0] v;
    logic [20:0]  s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   txn_no    = 0;

  always #5 clk = ~clk;

  vec_exec_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .mode_bcast(mode_bcast), .red_en(red_en), .vec_a(vec_a), .vec_b(vec_b),
    .scal(scal), .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
    .res_vec(res_vec), .res_sum(res_sum), .busy(busy), .lane_idx(lane_idx)
  );

  // Reference: lane-by-lane arithmetic straight from the op table, sum mod 2^21.
  function automatic exp_t model(input logic [2:0] o, input logic bc, input logic rd,
                                 input logic [191:0] a, input logic [191:0] b,
                                 input logic [20:0] s);
    exp_t        e;
    int unsigned sum;
    logic [23:0] x, y, r;
    e   = '0;
    sum = 0;
    for (int i = 0; i < L; i++) begin
      x = a[i*W +: W];
      y = bc ? {3'b000, s} : b[i*W +: W];
      case (o)
        3'd0:    r = x + y;
        3'd1:    r = x - y;
        3'd2:    r = x & y;
        3'd3:    r = x | y;
        3'd4:    r = x ^ y;
        3'd5:    r = (x > y) ? x : y;
        3'd6:    r = (x < y) ? x : y;
        default: r = x;
      endcase
      e.v[i*W +: W] = r;
      sum = (sum + r) % (1 << 21);
    end
    e.s = rd ? sum[20:0] : 21'd0;
    return e;
  endfunction

  function automatic logic [191:0] rvec();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chki(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  task automatic chkv(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && !flush && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_empty: got unexpected result %h required none", res_vec);
      end else begin
        mon_e = sb.pop_front();
        txn_no++;
        chkv("res_vec", res_vec, mon_e.v);
        chkv("res_sum", 192'(res_sum), 192'(mon_e.s));
        $display("txn %0d: res_vec=%h res_sum=%h", txn_no, res_vec, res_sum);
      end
    end
  end

  task automatic run_txn(input logic [2:0] o, input logic bc, input logic rd,
                         input logic [191:0] a, input logic [191:0] b,
                         input logic [20:0] s, input int hold);
    exp_t e;
    int   n;
    e = model(o, bc, rd, a, b, s);
    op = o; mode_bcast = bc; red_en = rd; vec_a = a; vec_b = b; scal = s;
    in_valid = 1'b1;
    chki("in_ready_idle", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    sb.push_back(e);
    chki("busy_run", int'(busy), 1);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chki("latency", n, 8);
    if (!res_valid) return;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      vec_a = rvec();
      chki("hold_valid", int'(res_valid), 1);
      chki("hold_in_ready", int'(in_ready), 0);
      chkv("hold_vec", res_vec, e.v);
      chkv("hold_sum", 192'(res_sum), 192'(e.s));
      tick();
    end
    res_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    res_ready = 1'b0;
    chki("post_valid", int'(res_valid), 0);
    chki("post_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [191:0] a, b;
    int           quiet;
    rst = 1'b0; in_valid = 1'b0; op = 3'd0; mode_bcast = 1'b0; red_en = 1'b0;
    vec_a = '0; vec_b = '0; scal = '0; flush = 1'b0; res_ready = 1'b0;
    tick(); tick();
    chki("rst_valid", int'(res_valid), 0);
    chkv("rst_vec", res_vec, 192'd0);
    chki("rst_sum", int'(res_sum), 0);
    chki("rst_lane", int'(lane_idx), 0);
    chki("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = 24'(i + 1);
      b[i*W +: W] = 24'h10;
    end
    run_txn(3'd0, 1'b0, 1'b1, a, b, 21'd0, 0);

    for (int i = 0; i < L; i++) b[i*W +: W] = 24'h1;
    run_txn(3'd1, 1'b0, 1'b1, 192'd0, b, 21'd0, 0);

    a = '1;
    run_txn(3'd2, 1'b1, 1'b0, a, rvec(), 21'h1FFFFF, 0);

    run_txn(3'd0, 1'b0, 1'b1, rvec(), rvec(), 21'd0, 5);

    // Flush mid-RUN at lane 3.
    op = 3'd3; mode_bcast = 1'b0; red_en = 1'b1; vec_a = rvec(); vec_b = rvec();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chki("flush_lane", int'(lane_idx), 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chki("flush_busy", int'(busy), 0);
    chki("flush_sum", int'(res_sum), 0);
    chki("flush_in_ready", int'(in_ready), 1);
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid) quiet++;
      tick();
    end
    chki("flush_no_valid", quiet, 0);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    chki("flush_beats_accept", int'(busy), 0);

    // Reset mid-RUN at lane 5.
    op = 3'd0; red_en = 1'b1; vec_a = rvec(); vec_b = rvec();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chki("rst_run_lane", int'(lane_idx), 5);
    rst = 1'b0;
    tick();
    chki("rst_run_valid", int'(res_valid), 0);
    chkv("rst_run_vec", res_vec, 192'd0);
    chki("rst_run_sum", int'(res_sum), 0);
    chki("rst_run_lane0", int'(lane_idx), 0);
    chki("rst_run_busy", int'(busy), 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = 24'h5;
      b[i*W +: W] = 24'h7;
    end
    run_txn(3'd5, 1'b0, 1'b0, a, b, 21'd0, 0);

    for (int t = 0; t < 20; t++) begin
      run_txn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rvec(), rvec(), 21'($urandom), $urandom_range(0, 3));
    end

    tick(); tick(); tick();
    chki("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
